fifo_sync_prog: RTL
===================

// Module: fifo_sync_prog
// PURPOSE
//   Next-generation single-clock FIFO for the SNN SoC datapaths (spike/event queues, DMA staging).
//   Adds non-power-of-2 depth, programmable almost-full/almost-empty thresholds, FWFT or registered-read
//   mode, synchronous flush, full-with-pop bypass and sticky error flags. Single writer, single reader.
// PARAMETERS
//   WIDTH  8   data word width in bits (>=1)
//   DEPTH  16  entries (>=2, any integer; pointers wrap at DEPTH-1 -> 0)
//   FWFT   1   1: first-word-fall-through read; 0: registered read (data valid 1 cycle after pop)
//   CNT_W  (localparam) $clog2(DEPTH+1)
// PORTS
//   clk          in   1      clock
//   rst          in   1      synchronous reset, active-high
//   flush        in   1      synchronous clear of contents; sticky flags unaffected
//   push         in   1      write request
//   push_data    in   WIDTH  write data
//   pop          in   1      read request
//   rd_data      out  WIDTH  read data (see BEHAVIOUR)
//   rd_valid     out  1      rd_data valid
//   empty        out  1      count==0
//   full         out  1      count==DEPTH
//   count        out  CNT_W  occupancy
//   afull_thr    in   CNT_W  almost_full threshold
//   aempty_thr   in   CNT_W  almost_empty threshold
//   almost_full  out  1      count >= afull_thr
//   almost_empty out  1      count <= aempty_thr
//   overflow     out  1      1-cycle pulse: rejected push
//   underflow    out  1      1-cycle pulse: rejected pop
//   err_sticky   out  2      {ovf,udf} sticky; set on pulse, cleared by err_clr or rst
//   err_clr      in   1      clear err_sticky (set wins if same cycle)
//   max_level    out  CNT_W  peak occupancy (optional, see CONFIGURATION)
// BEHAVIOUR
//   - Reset (rst=1 at edge): pointers, count, rd_data, rd_valid, overflow, underflow, err_sticky,
//     max_level = 0. Outputs are empty=1, full=0, almost_empty=1, almost_full=(afull_thr==0).
//   - pop_fire = pop && !empty.  push_fire = push && (!full || pop_fire).
//     So a push with a pop on a full FIFO is accepted and count stays DEPTH.
//   - Push/pop on an empty FIFO in the same cycle: push accepted, pop rejected, underflow pulses.
//   - count update: +1 on push-only, -1 on pop-only, unchanged on both or neither.
//     empty/full/almost_* are combinational from the count register.
//   - overflow = registered (push && !push_fire); underflow = registered (pop && !pop_fire).
//     Both assert the cycle after the request.
//   - FWFT=1: rd_data = mem[rd_ptr] when !empty; rd_valid = !empty; pop consumes the shown word.
//   - FWFT=0: on pop_fire, rd_data <= mem[rd_ptr] and rd_valid <= 1 for exactly one cycle.
//     rd_data holds its value otherwise.
//   - flush has priority over push/pop in the same cycle: both are ignored, no overflow/underflow,
//     pointers/count <= 0, rd_valid <= 0. Contents are not zeroed.
//   - rst has priority over flush. Reset mid-operation discards all data; there is no partial state.
//   - Thresholds are sampled live. Threshold values above DEPTH are legal: almost_full then never
//     asserts and almost_empty always asserts.
// CONFIGURATION
//   FIFO_SYNC_PROG_WMARK_EN defined: max_level <= max(max_level, next count) every cycle.
//     It is cleared by rst or err_clr and is not cleared by flush.
//   Not defined: max_level tied to 0 and no tracking logic is built.
// TESTING
//   1. DEPTH=5, FWFT=1: push 5 words A0..A4 -> full=1, count=5. A 6th push -> overflow pulses
//      1 cycle later and err_sticky[1]=1. Pop x5 returns A0..A4 in order; wrap is verified.
//   2. Full FIFO, push+pop same cycle -> count stays 5, no overflow, next read order preserved.
//   3. Empty FIFO, pop -> underflow pulse, count=0. Push+pop same cycle -> count=1, underflow=1.
//   4. FWFT=0: push 0x3C, pop -> rd_valid=1 with rd_data=0x3C on the next cycle only.
//   5. afull_thr=3, aempty_thr=1: count 0..4 -> almost_empty 1,1,0,0,0; almost_full 0,0,0,1,1.
//   6. Fill to 4, flush+push same cycle -> count=0, empty=1, no overflow, err_sticky unchanged.
//      With WMARK_EN, max_level stays 4 until err_clr.

Source files
------------

// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog: single-clock FIFO with any depth >= 2, programmable
// almost-full/almost-empty thresholds, FWFT or registered read, synchronous
// flush, push-while-full-with-pop bypass and sticky {overflow, underflow} flags.
// Optional peak-occupancy tracking is built when FIFO_SYNC_PROG_WMARK_EN is defined;
// otherwise max_level is tied to zero.
module fifo_sync_prog #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int FWFT  = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] afull_thr,
  input  logic [CNT_W-1:0] aempty_thr,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  output logic [1:0]       err_sticky,
  input  logic             err_clr,
  output logic [CNT_W-1:0] max_level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic [1:0]       sticky_reg, sticky_next;
  logic             pop_fire, push_fire;

  // Status flags come straight from the occupancy register; thresholds are live.
  assign empty        = (count_reg == '0);
  assign full         = (count_reg == DEPTH_C);
  assign almost_full  = (count_reg >= afull_thr);
  assign almost_empty = (count_reg <= aempty_thr);
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;
  assign err_sticky   = sticky_reg;

  // Accept/reject decisions and next-state; flush overrides push and pop entirely.
  always_comb begin
    pop_fire       = pop && !empty;
    push_fire      = push && (!full || pop_fire);
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_fire) begin
        wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      end
      if (push_fire && !pop_fire) begin
        count_next = count_reg + 1'b1;
      end else if (pop_fire && !push_fire) begin
        count_next = count_reg - 1'b1;
      end
      overflow_next  = push && !push_fire;
      underflow_next = pop && !pop_fire;
    end
    // A new error event wins over a simultaneous clear.
    sticky_next = (sticky_reg & {2{!err_clr}}) | {overflow_next, underflow_next};
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      sticky_reg    <= 2'b00;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      sticky_reg    <= sticky_next;
    end
  end

  // Storage write; contents are never cleared, only the pointers are.
  always_ff @(posedge clk) begin
    if (push_fire && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally whenever the FIFO holds data.
      assign rd_data  = empty ? '0 : mem[rd_ptr_reg];
      assign rd_valid = !empty;
    end else begin : g_reg_read
      logic [WIDTH-1:0] rd_data_reg;
      logic             rd_valid_reg;
      // Registered read: a full-with-pop write to the same slot returns the old word.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= pop_fire && !flush;
          if (pop_fire && !flush) begin
            rd_data_reg <= mem[rd_ptr_reg];
          end
        end
      end
      assign rd_data  = rd_data_reg;
      assign rd_valid = rd_valid_reg;
    end
  endgenerate

`ifdef FIFO_SYNC_PROG_WMARK_EN
  logic [CNT_W-1:0] max_level_reg;
  // Peak occupancy; flush leaves it alone, err_clr restarts tracking.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      max_level_reg <= '0;
    end else if (count_next > max_level_reg) begin
      max_level_reg <= count_next;
    end
  end
  assign max_level = max_level_reg;
`else
  assign max_level = '0;
`endif

endmodule
